wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: register-file write, flag register, redirect generation and post-redirect flush.
// Optional WB_PERF_EN macro enables the retired/squashed instruction counters.
module wb_stage #(
    parameter int FLUSH_DEPTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  writeBackControl_wb,
    input  logic        regWrt_wb,
    input  logic        branchZero_wb,
    input  logic        branchNeg_wb,
    input  logic        jump_wb,
    input  logic        jumpMem_wb,
    input  logic [5:0]  rd_wb,
    input  logic [31:0] pc_plus_y_wb,
    input  logic [31:0] xrs_wb,
    input  logic [31:0] readData_wb,
    input  logic [31:0] aluResult_wb,
    input  logic        z_wb,
    input  logic        n_wb,
    output logic        rf_we,
    output logic [5:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        zflag,
    output logic        nflag,
    output logic [31:0] retired_count,
    output logic [31:0] squash_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    logic [2:0]  flush_cnt;
    logic        active;
    logic        live;
    logic        do_write;
    logic        flag_load;
    logic        taken;
    logic [31:0] target;
    logic [31:0] wdata_next;

    assign flush     = (flush_cnt != 3'd0);
    assign active    = regWrt_wb | branchZero_wb | branchNeg_wb | jump_wb | jumpMem_wb;
    assign live      = ~flush;
    assign do_write  = regWrt_wb & live;
    // Only ALU-sourced writes (ctl 00, or reserved 11 aliased to it) carry meaningful flags.
    assign flag_load = do_write & (writeBackControl_wb[1] == writeBackControl_wb[0]);

    always_comb begin
        wdata_next = aluResult_wb;
        case (writeBackControl_wb)
            2'b01:   wdata_next = readData_wb;
            2'b10:   wdata_next = pc_plus_y_wb;
            default: wdata_next = aluResult_wb;
        endcase
    end

    // Branch conditions read the flag register before this instruction's own update.
    always_comb begin
        taken  = 1'b0;
        target = xrs_wb;
        if (live) begin
            if (jumpMem_wb) begin
                taken  = 1'b1;
                target = readData_wb;
            end else if (jump_wb) begin
                taken  = 1'b1;
            end else if (branchZero_wb && zflag) begin
                taken  = 1'b1;
            end else if (branchNeg_wb && nflag) begin
                taken  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 6'd0;
            rf_wdata <= 32'd0;
        end else if (do_write) begin
            rf_we    <= 1'b1;
            rf_waddr <= rd_wb;
            rf_wdata <= wdata_next;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            zflag <= 1'b0;
            nflag <= 1'b0;
        end else if (flag_load) begin
            zflag <= z_wb;
            nflag <= n_wb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            redirect <= taken;
            if (taken)
                redirect_pc <= target;
        end
    end

    // Counter loads on the redirecting edge, so flush rises together with redirect.
    always_ff @(posedge clock) begin
        if (reset)
            flush_cnt <= 3'd0;
        else if (taken)
            flush_cnt <= FLUSH_LOAD;
        else if (flush)
            flush_cnt <= flush_cnt - 3'd1;
    end

`ifdef WB_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] squash_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= 32'd0;
            squash_q  <= 32'd0;
        end else if (active) begin
            if (live)
                retired_q <= retired_q + 32'd1;
            else
                squash_q  <= squash_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
    assign squash_count  = squash_q;
`else
    logic unused_active;
    assign unused_active = active;
    assign retired_count = 32'd0;
    assign squash_count  = 32'd0;
`endif

endmodule
